id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the RV32I core.
- Captures the control bundle from the main/ALU decoders and the decode-stage datapath values, and presents them to the execute stage one cycle later.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Keeps a valid bit and two event counters for stall/flush profiling.

Parameters:
- DATA_WIDTH, 32, width of register operands, PC and immediate
- REG_ADDR_WIDTH, 5, register index width
- ALUCTRL_WIDTH, 4, width of ALUControl code
- CNT_WIDTH, 32, width of profiling counters

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- StallE  input  1  hold current E contents
- FlushE  input  1  replace next E contents with bubble
- ValidD  input  1  decode stage holds a real instruction
- RegWriteD  input  1  control from decoder
- ResultSrcD  input  2  00 ALU, 01 memory, 10 PC+4
- MemWriteD  input  1  control from decoder
- JumpD  input  1  control from decoder
- BranchD  input  1  control from decoder
- ALUSrcD  input  1  0 register, 1 immediate
- ALUControlD  input  ALUCTRL_WIDTH  ALU operation code
- Funct3D  input  3  branch/load/store sub-op
- RD1D, RD2D  input  DATA_WIDTH  register file read data
- PCD, PCPlus4D, ImmExtD  input  DATA_WIDTH  PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  input  REG_ADDR_WIDTH  register indices
- Every D input above except ValidD has a matching ...E output of the same width (e.g. RegWriteE, RD1E, RdE).
- ValidE  output  1  execute stage holds a real instruction
- StallCnt  output  CNT_WIDTH  cycles with StallE=1 and FlushE=0
- FlushCnt  output  CNT_WIDTH  cycles with FlushE=1

Behaviour:
- Reset:
  - When rst=1 at a rising edge, every E output, ValidE, StallCnt and FlushCnt become 0.
  - rst dominates StallE and FlushE.
  - A reset mid-stream drops the in-flight instruction with no partial state.
- Priority on each edge: rst > FlushE > StallE > normal load.
- Normal load (StallE=0, FlushE=0):
  - All E registers take their D values.
  - ValidE <= ValidD.
  - Latency is exactly one cycle.
- Flush (FlushE=1, regardless of StallE):
  - Bubble: ValidE=0, and RegWriteE, MemWriteE, JumpE, BranchE are all 0.
  - ResultSrcE=00, ALUSrcE=0, ALUControlE=0, Funct3E=0.
  - RdE=Rs1E=Rs2E=0, so the forwarding unit never matches.
  - Data fields (RD1E, RD2E, PCE, PCPlus4E, ImmExtE) are cleared to 0.
- Stall (StallE=1, FlushE=0): every E register and ValidE hold their value.
- ValidD=0 with normal load: the whole D bundle is captured as-is, but RegWriteE and MemWriteE are forced to 0. An invalid slot can therefore never commit state.
- Counters:
  - FlushCnt increments by 1 on every non-reset edge with FlushE=1.
  - StallCnt increments by 1 on every non-reset edge with StallE=1 and FlushE=0.
  - Both wrap modulo 2^CNT_WIDTH, with no saturation.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package (core_pkg):
  - ResultSrc encodings: RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10.
  - ALUControl code constants.
  - A packed struct ctrl_t bundling RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl and Funct3, plus the constant CTRL_BUBBLE (all zero).
- Sub-module pipe_reg: a generic WIDTH-parameterised register with rst, en and clr inputs, where clr beats en.
  - Instantiate one for ctrl_t, one for the data bundle and one for the indices.
  - The valid bit, write-enable gating and counters stay in id_ex_reg.

Test Plan:
- Reset → hold rst=1 for 2 cycles with nonzero D inputs → all E outputs, ValidE, StallCnt and FlushCnt read 0; release rst → next edge ValidE follows ValidD.
- Pass-through → ValidD=1, RegWriteD=1, ResultSrcD=01, RdD=5, RD1D=32'h1000_0004, ImmExtD=32'hFFFF_FFF8 → one edge later the E outputs equal these values and ValidE=1.
- Stall then flush on the same edge → load RdD=7; next edge assert StallE=1 and FlushE=1 → RdE=0, RegWriteE=0, ValidE=0, FlushCnt=1, StallCnt=0.
- Stall hold → load PCD=32'h0000_0040; assert StallE for 3 cycles while D inputs change → PCE stays 32'h40 and StallCnt=3; deassert → next edge PCE takes the new PCD.
- Invalid-slot gating → ValidD=0, RegWriteD=1, MemWriteD=1 → RegWriteE=0, MemWriteE=0, ValidE=0, while the other fields are captured.
- Counter wrap → CNT_WIDTH=4, assert FlushE for 17 cycles → FlushCnt=1; rst=1 during a stall → StallCnt returns to 0 on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the RV32I core pipeline.
//   - ResultSrc encodings and ALUControl operation codes
//   - ctrl_t: packed control bundle produced by the decoders
//   - CTRL_BUBBLE: all-zero control bundle used for flushed slots
package core_pkg;

    localparam int ALUCTRL_W = 4;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 4'b0110;
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic                 alu_src;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [2:0]           funct3;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_pipe.sv
// pipe_reg: generic WIDTH-bit pipeline register.
//   clk, rst : clock, synchronous active-high reset (clears q)
//   en       : load d into q
//   clr      : load zero into q; wins over en
//   d, q     : data in / registered data out
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register of the RV32I core.
//   Inputs : clk, rst (sync, active high), StallE (hold), FlushE (bubble),
//            ValidD plus the decode control bundle, operands, PC values,
//            immediate and register indices.
//   Outputs: matching ...E registers, ValidE, and StallCnt/FlushCnt
//            profiling counters. All outputs are registered.
// Priority on each edge: rst > FlushE > StallE > load.
module id_ex_reg
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUCTRL_WIDTH  = ALUCTRL_W,  // must match the ctrl_t field
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic [1:0]                ResultSrcD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcD,
    input  logic [ALUCTRL_WIDTH-1:0]  ALUControlD,
    input  logic [2:0]                Funct3D,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      RegWriteE,
    output logic [1:0]                ResultSrcE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic [ALUCTRL_WIDTH-1:0]  ALUControlE,
    output logic [2:0]                Funct3E,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      ValidE,
    output logic [CNT_WIDTH-1:0]      StallCnt,
    output logic [CNT_WIDTH-1:0]      FlushCnt
);

    localparam int DATA_BUS_W = 5 * DATA_WIDTH;
    localparam int IDX_BUS_W  = 3 * REG_ADDR_WIDTH;

    ctrl_t                  ctrl_d, ctrl_e;
    logic [DATA_BUS_W-1:0]  data_d, data_e;
    logic [IDX_BUS_W-1:0]   idx_d, idx_e;
    logic                   load;

    assign load = ~StallE;

    // An invalid slot keeps its payload but can never write the register
    // file or memory.
    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = RegWriteD & ValidD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.mem_write   = MemWriteD & ValidD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.funct3      = Funct3D;
    end

    assign data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD};
    assign idx_d  = {Rs1D, Rs2D, RdD};

    pipe_reg #(.WIDTH($bits(ctrl_t))) u_ctrl (
        .clk(clk), .rst(rst), .en(load), .clr(FlushE), .d(ctrl_d), .q(ctrl_e)
    );

    pipe_reg #(.WIDTH(DATA_BUS_W)) u_data (
        .clk(clk), .rst(rst), .en(load), .clr(FlushE), .d(data_d), .q(data_e)
    );

    // Clearing indices on flush keeps the forwarding unit from matching a bubble.
    pipe_reg #(.WIDTH(IDX_BUS_W)) u_idx (
        .clk(clk), .rst(rst), .en(load), .clr(FlushE), .d(idx_d), .q(idx_e)
    );

    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcE  = ctrl_e.result_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign JumpE       = ctrl_e.jump;
    assign BranchE     = ctrl_e.branch;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUControlE = ctrl_e.alu_control;
    assign Funct3E     = ctrl_e.funct3;

    assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE} = data_e;
    assign {Rs1E, Rs2E, RdE}                    = idx_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            ValidE   <= 1'b0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (FlushE) begin
            ValidE   <= 1'b0;
            FlushCnt <= FlushCnt + 1'b1;
        end else if (StallE) begin
            StallCnt <= StallCnt + 1'b1;
        end else begin
            ValidE   <= ValidD;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for id_ex_reg.
// A second instance with CNT_WIDTH=4 shares all inputs to exercise wrap.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, StallE, FlushE, ValidD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic [2:0]  Funct3D;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE, StallCnt, FlushCnt;
    logic [4:0]  Rs1E, Rs2E, RdE;

    logic        w_rw, w_mw, w_j, w_b, w_as, w_v;
    logic [1:0]  w_rs;
    logic [3:0]  w_ac;
    logic [2:0]  w_f3;
    logic [31:0] w_rd1, w_rd2, w_pc, w_pc4, w_imm;
    logic [4:0]  w_s1, w_s2, w_d;
    logic [3:0]  w_scnt, w_fcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    id_ex_reg #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .Funct3D(Funct3D),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteE(w_rw), .ResultSrcE(w_rs), .MemWriteE(w_mw),
        .JumpE(w_j), .BranchE(w_b), .ALUSrcE(w_as),
        .ALUControlE(w_ac), .Funct3E(w_f3),
        .RD1E(w_rd1), .RD2E(w_rd2), .PCE(w_pc), .PCPlus4E(w_pc4), .ImmExtE(w_imm),
        .Rs1E(w_s1), .Rs2E(w_s2), .RdE(w_d),
        .ValidE(w_v), .StallCnt(w_scnt), .FlushCnt(w_fcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b1;
        RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1; ALUSrcD = 1'b1;
        ResultSrcD = 2'b10; ALUControlD = 4'h5; Funct3D = 3'h3;
        RD1D = 32'h11; RD2D = 32'h22; PCD = 32'h33; PCPlus4D = 32'h37; ImmExtD = 32'h44;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;

        // reset held two cycles with nonzero inputs
        step(); step();
        chk("rst_regwrite", RegWriteE, 0);
        chk("rst_memwrite", MemWriteE, 0);
        chk("rst_aluctl",   ALUControlE, 0);
        chk("rst_rd1",      RD1E, 0);
        chk("rst_pc",       PCE, 0);
        chk("rst_rd",       RdE, 0);
        chk("rst_valid",    ValidE, 0);
        chk("rst_stallcnt", StallCnt, 0);
        chk("rst_flushcnt", FlushCnt, 0);
        rst = 1'b0;
        step();
        chk("post_rst_valid", ValidE, 1);

        // pass-through
        RegWriteD = 1'b1; ResultSrcD = 2'b01; RdD = 5'd5;
        RD1D = 32'h1000_0004; ImmExtD = 32'hFFFF_FFF8;
        step();
        chk("pt_regwrite", RegWriteE, 1);
        chk("pt_resultsrc", ResultSrcE, 2'b01);
        chk("pt_rd",       RdE, 5);
        chk("pt_rd1",      RD1E, 32'h1000_0004);
        chk("pt_imm",      ImmExtE, 32'hFFFF_FFF8);
        chk("pt_valid",    ValidE, 1);

        // stall and flush on the same edge: flush wins
        RdD = 5'd7;
        step();
        chk("sf_load_rd", RdE, 7);
        StallE = 1'b1; FlushE = 1'b1;
        step();
        chk("sf_rd",       RdE, 0);
        chk("sf_regwrite", RegWriteE, 0);
        chk("sf_valid",    ValidE, 0);
        chk("sf_flushcnt", FlushCnt, 1);
        chk("sf_stallcnt", StallCnt, 0);
        chk("sf_imm",      ImmExtE, 0);
        chk("sf_resultsrc", ResultSrcE, 0);
        chk("sf_alusrc",   ALUSrcE, 0);
        chk("sf_funct3",   Funct3E, 0);
        chk("sf_pc4",      PCPlus4E, 0);
        chk("sf_rs1",      Rs1E, 0);

        // stall hold
        StallE = 1'b0; FlushE = 1'b0; PCD = 32'h0000_0040;
        step();
        chk("sh_load_pc", PCE, 32'h40);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PCD = 32'h100 + i * 4;
            RdD = 5'(10 + i);
            step();
        end
        chk("sh_pc_held", PCE, 32'h40);
        chk("sh_rd_held", RdE, 7);
        chk("sh_valid_held", ValidE, 1);
        chk("sh_stallcnt", StallCnt, 3);
        StallE = 1'b0; PCD = 32'h0000_0200;
        step();
        chk("sh_pc_new", PCE, 32'h200);
        chk("sh_stallcnt_after", StallCnt, 3);

        // invalid slot: payload captured, writes gated
        ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1;
        RdD = 5'd9; RD2D = 32'hCAFE_F00D;
        step();
        chk("inv_regwrite", RegWriteE, 0);
        chk("inv_memwrite", MemWriteE, 0);
        chk("inv_valid",    ValidE, 0);
        chk("inv_jump",     JumpE, 1);
        chk("inv_rd",       RdE, 9);
        chk("inv_rd2",      RD2E, 32'hCAFE_F00D);

        // counter wrap on the 4-bit instance
        ValidD = 1'b1;
        rst = 1'b1;
        step();
        chk("wr_rst_fcnt4", w_fcnt, 0);
        rst = 1'b0; FlushE = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk("wr_fcnt4", w_fcnt, 1);
        chk("wr_fcnt32", FlushCnt, 17);
        FlushE = 1'b0; StallE = 1'b1;
        step(); step();
        chk("wr_scnt4", w_scnt, 2);
        rst = 1'b1;
        step();
        chk("wr_rst_scnt", StallCnt, 0);
        chk("wr_rst_scnt4", w_scnt, 0);
        chk("wr_rst_valid", ValidE, 0);
        rst = 1'b0; StallE = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
